// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//
// Purpose:
//   Valid/ready pipelined adder/subtractor. The WIDTH-bit operation is split
//   into STAGES equal slices. Slice k is added in pipeline stage k using the
//   registered carry of slice k-1. Operand bits not yet consumed and sum bits
//   already produced travel alongside in skew registers, so each operation
//   moves through the pipe as one aligned token.
//
// Parameters:
//   WIDTH   operand/result width, 4..64
//   STAGES  pipeline depth, 1..WIDTH, WIDTH must be a multiple of STAGES
//
// Ports:
//   clk        clock, all state on its rising edge
//   rst        asynchronous active-high reset
//   in_valid   a/b/cin/sub carry an operation
//   in_ready   operation accepted this cycle (equals the pipeline advance)
//   a, b       operands (unsigned or two's complement)
//   cin        carry-in (borrow-in when sub=1)
//   sub        0 = add, 1 = subtract (a - b)
//   out_valid  sum/cout/overflow hold a result
//   out_ready  downstream takes the result this cycle
//   sum        result bits, wraps modulo 2^WIDTH
//   cout       carry out of the MSB (in subtract mode 1 = no borrow)
//   overflow   signed overflow flag
//
// Build option:
//   PIPELINED_ADDER_OVF_EN  when defined, overflow = (carry into MSB) XOR
//                           (carry out of MSB), registered with the final
//                           slice. When undefined, overflow is tied to 0.
// -----------------------------------------------------------------------------
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  // Width of the slice handled by each stage.
  localparam int SW = WIDTH / STAGES;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // The whole pipe moves together; it only freezes when the last stage holds
  // a result nobody is taking. Bubbles are never squeezed out.
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  // Subtraction is a + ~b + 1; an incoming borrow flips the +1 away.
  assign b_eff = b ^ {WIDTH{sub}};
  assign c_eff = cin ^ sub;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO = gi * SW;  // first bit of this stage's slice
    localparam int HI = LO + SW;  // first bit of the next stage's slice

    // Stage inputs: remaining operand bits, incoming carry, valid.
    logic [WIDTH-1:LO] a_in;
    logic [WIDTH-1:LO] b_in;
    logic              c_in;
    logic              v_in;

    logic [SW:0]       slice_sum;
    logic [HI-1:0]     sum_next;

    // Stage register: sum bits completed so far, carry out of this slice.
    logic [HI-1:0]     sum_reg;
    logic              carry_reg;
    logic              valid_reg;

    if (gi == 0) begin : g_head
      assign a_in     = a;
      assign b_in     = b_eff;
      assign c_in     = c_eff;
      assign v_in     = in_valid;
      assign sum_next = slice_sum[SW-1:0];
    end else begin : g_body
      assign a_in     = g_stage[gi-1].g_skew.a_reg;
      assign b_in     = g_stage[gi-1].g_skew.b_reg;
      assign c_in     = g_stage[gi-1].carry_reg;
      assign v_in     = g_stage[gi-1].valid_reg;
      assign sum_next = {slice_sum[SW-1:0], g_stage[gi-1].sum_reg};
    end

    assign slice_sum = {1'b0, a_in[LO +: SW]}
                     + {1'b0, b_in[LO +: SW]}
                     + {{SW{1'b0}}, c_in};

    // Data is captured even for bubbles; only valid_reg gives it meaning.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_reg <= 1'b0;
        carry_reg <= 1'b0;
        sum_reg   <= '0;
      end else if (advance) begin
        valid_reg <= v_in;
        carry_reg <= slice_sum[SW];
        sum_reg   <= sum_next;
      end
    end

    // Operand bits still to be added by later stages. The last stage has
    // nothing left to forward.
    if (gi < STAGES - 1) begin : g_skew
      logic [WIDTH-1:HI] a_reg;
      logic [WIDTH-1:HI] b_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_reg <= '0;
          b_reg <= '0;
        end else if (advance) begin
          a_reg <= a_in[WIDTH-1:HI];
          b_reg <= b_in[WIDTH-1:HI];
        end
      end
    end

`ifdef PIPELINED_ADDER_OVF_EN
    // The MSB lives in the last slice. Carry into the MSB is recovered from
    // the MSB sum bit and its two addend bits.
    if (gi == STAGES - 1) begin : g_ovf
      logic msb_carry_in;
      logic ovf_reg;

      assign msb_carry_in = a_in[WIDTH-1] ^ b_in[WIDTH-1] ^ slice_sum[SW-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_reg <= 1'b0;
        end else if (advance) begin
          ovf_reg <= msb_carry_in ^ slice_sum[SW];
        end
      end
    end
`endif
  end

  assign out_valid = g_stage[STAGES-1].valid_reg;
  assign sum       = g_stage[STAGES-1].sum_reg;
  assign cout      = g_stage[STAGES-1].carry_reg;

`ifdef PIPELINED_ADDER_OVF_EN
  assign overflow = g_stage[STAGES-1].g_ovf.ovf_reg;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_adder
//
// Self-checking bench for pipelined_adder. Main instance WIDTH=16, STAGES=4;
// a second instance WIDTH=8, STAGES=1 covers the single-stage case.
// Inputs are driven on the falling edge; outputs are sampled 1 ns later.
// Expected results come from a plain-arithmetic model and a FIFO scoreboard.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipelined_adder;

  localparam int W = 16;
  localparam int S = 4;

`ifdef PIPELINED_ADDER_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, overflow;
  logic [W-1:0] a, b, sum;

  logic         in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, overflow8;
  logic [7:0]   a8, b8, sum8;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  res_t exp_q[$];

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow)
  );

  pipelined_adder #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .overflow(overflow8)
  );

  // Reference: integer arithmetic on the true operand values.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic su);
    res_t   r;
    longint full, half, ux, uy, sx, sy, c, total, stotal;
    full = longint'(1) << W;
    half = longint'(1) << (W - 1);
    ux = longint'(x);
    uy = longint'(y);
    sx = (ux >= half) ? ux - full : ux;
    sy = (uy >= half) ? uy - full : uy;
    c  = ci ? 1 : 0;
    if (su) begin
      total  = ux - uy - c;
      stotal = sx - sy - c;
      r.cout = (total >= 0);
    end else begin
      total  = ux + uy + c;
      stotal = sx + sy + c;
      r.cout = (total >= full);
    end
    r.sum = total[W-1:0];
    r.ovf = OVF_ON && ((stotal >= half) || (stotal < -half));
    return r;
  endfunction

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(W-1){1'b0}}};
      3:       v = {1'b0, {(W-1){1'b1}}};
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input logic su, input logic rdy);
    @(negedge clk);
    in_valid  = v;
    a         = x;
    b         = y;
    cin       = ci;
    sub       = su;
    out_ready = rdy;
    #1;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, '0, '0, 1'b0, 1'b0, rdy);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(1'b0);
    idle(1'b0);
    checks++;
    if (out_valid !== 1'b0)
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    if (out_valid !== 1'b0) failures++;
    checks++;
    if (sum !== '0 || cout !== 1'b0 || overflow !== 1'b0) begin
      $display("FAIL reset_data: got sum=%h cout=%b ovf=%b want 0/0/0", sum, cout, overflow);
      failures++;
    end
    checks++;
    if (out_valid8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
      $display("FAIL reset_dut8: got v=%b sum=%h cout=%b want 0/00/0", out_valid8, sum8, cout8);
      failures++;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
      failures++;
    end
    checks++;
    if (in_ready8 !== 1'b1) begin
      $display("FAIL reset_in_ready8: got %b want 1", in_ready8);
      failures++;
    end
    $display("test_reset done");
  endtask

  task automatic test_latency();
    drive(1'b1, 16'h1234, 16'h0F0F, 1'b0, 1'b0, 1'b1);
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL latency_accept: got in_ready=%b want 1", in_ready);
      failures++;
    end
    for (int i = 1; i <= S; i++) begin
      idle(1'b1);
      checks++;
      if (out_valid !== (i == S)) begin
        $display("FAIL latency_valid: edge %0d got out_valid=%b want %b", i, out_valid, (i == S));
        failures++;
      end
    end
    checks++;
    if (sum !== 16'h2143 || cout !== 1'b0) begin
      $display("FAIL latency_result: got sum=%h cout=%b want 2143/0", sum, cout);
      failures++;
    end
    idle(1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL latency_dup: got out_valid=%b want 0", out_valid);
      failures++;
    end
    $display("test_latency 1234+0F0F -> sum=%h cout=%b", 16'h2143, 1'b0);
  endtask

  task automatic test_wrap();
    res_t want [2];
    int   got;
    want[0] = '{16'h0000, 1'b1, 1'b0};
    want[1] = '{16'hFFFE, 1'b0, 1'b0};
    got = 0;
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
    for (int cyc = 0; cyc < 20 && got < 2; cyc++) begin
      idle(1'b1);
      if (out_valid === 1'b1) begin
        checks++;
        if (sum !== want[got].sum || cout !== want[got].cout || overflow !== want[got].ovf) begin
          $display("FAIL wrap_%0d: got sum=%h cout=%b ovf=%b want %h/%b/%b", got, sum, cout,
                   overflow, want[got].sum, want[got].cout, want[got].ovf);
          failures++;
        end
        $display("test_wrap result %0d sum=%h cout=%b", got, sum, cout);
        got++;
      end
    end
    checks++;
    if (got != 2) begin
      $display("FAIL wrap_timeout: got %0d results want 2", got);
      failures++;
    end
  endtask

  task automatic test_overflow();
    res_t want [2];
    int   got;
    want[0] = '{16'h8000, 1'b0, OVF_ON};
    want[1] = '{16'h7FFF, 1'b1, OVF_ON};
    got = 0;
    drive(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    for (int cyc = 0; cyc < 20 && got < 2; cyc++) begin
      idle(1'b1);
      if (out_valid === 1'b1) begin
        checks++;
        if (sum !== want[got].sum || cout !== want[got].cout || overflow !== want[got].ovf) begin
          $display("FAIL overflow_%0d: got sum=%h cout=%b ovf=%b want %h/%b/%b", got, sum, cout,
                   overflow, want[got].sum, want[got].cout, want[got].ovf);
          failures++;
        end
        $display("test_overflow result %0d sum=%h ovf=%b", got, sum, overflow);
        got++;
      end
    end
    checks++;
    if (got != 2) begin
      $display("FAIL overflow_timeout: got %0d results want 2", got);
      failures++;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] xa [8];
    logic [W-1:0] xb [8];
    logic         xc [8];
    logic         xs [8];
    logic [W-1:0] held_sum;
    logic         held_cout, held_ovf;
    int           sent, got;
    sent = 0;
    got  = 0;
    held_sum  = '0;
    held_cout = 1'b0;
    held_ovf  = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      xa[i] = rand_operand();
      xb[i] = rand_operand();
      xc[i] = 1'($urandom_range(0, 1));
      xs[i] = 1'($urandom_range(0, 1));
    end
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      logic rdy;
      rdy = !(cyc >= 5 && cyc < 8);
      if (sent < 8) drive(1'b1, xa[sent], xb[sent], xc[sent], xs[sent], rdy);
      else          idle(rdy);
      if (!rdy) begin
        checks++;
        if (in_ready !== 1'b0) begin
          $display("FAIL b2b_stall_in_ready: cycle %0d got %b want 0", cyc, in_ready);
          failures++;
        end
        if (cyc > 5) begin
          checks++;
          if (out_valid !== 1'b1 || sum !== held_sum || cout !== held_cout || overflow !== held_ovf) begin
            $display("FAIL b2b_hold: cycle %0d got v=%b sum=%h cout=%b want 1/%h/%b", cyc,
                     out_valid, sum, cout, held_sum, held_cout);
            failures++;
          end
        end
        held_sum  = sum;
        held_cout = cout;
        held_ovf  = overflow;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, sub));
        sent++;
      end
      if (out_valid && out_ready) begin
        res_t e;
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL b2b_spurious: got sum=%h with nothing outstanding", sum);
          failures++;
        end else begin
          e = exp_q.pop_front();
          if (sum !== e.sum || cout !== e.cout || overflow !== e.ovf) begin
            $display("FAIL b2b_result_%0d: got sum=%h cout=%b ovf=%b want %h/%b/%b", got,
                     sum, cout, overflow, e.sum, e.cout, e.ovf);
            failures++;
          end
        end
        $display("test_back_to_back result %0d sum=%h cout=%b ovf=%b", got, sum, cout, overflow);
        got++;
      end
    end
    checks++;
    if (sent != 8 || got != 8 || exp_q.size() != 0) begin
      $display("FAIL b2b_count: got sent=%0d received=%0d pending=%0d want 8/8/0", sent, got,
               exp_q.size());
      failures++;
    end
    idle(1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL b2b_dup: got out_valid=%b want 0", out_valid);
      failures++;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] held_sum;
    logic         held_cout, held_ovf, stalled_prev;
    int           sent, got, errs;
    sent = 0;
    got  = 0;
    errs = 0;
    stalled_prev = 1'b0;
    held_sum  = '0;
    held_cout = 1'b0;
    held_ovf  = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic v, rdy;
      v   = (cyc < 340) && ($urandom_range(0, 3) != 0);
      rdy = (cyc >= 340) || ($urandom_range(0, 3) != 0);
      drive(v, rand_operand(), rand_operand(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), rdy);
      if (stalled_prev) begin
        checks++;
        if (out_valid !== 1'b1 || sum !== held_sum || cout !== held_cout || overflow !== held_ovf) begin
          $display("FAIL rand_hold: cycle %0d got v=%b sum=%h want 1/%h", cyc, out_valid, sum, held_sum);
          failures++;
        end
      end
      stalled_prev = out_valid && !out_ready;
      held_sum  = sum;
      held_cout = cout;
      held_ovf  = overflow;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, sub));
        sent++;
      end
      if (out_valid && out_ready) begin
        res_t e;
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL rand_spurious: got sum=%h with nothing outstanding", sum);
          failures++;
        end else begin
          e = exp_q.pop_front();
          if (sum !== e.sum || cout !== e.cout || overflow !== e.ovf) begin
            $display("FAIL rand_result_%0d: got sum=%h cout=%b ovf=%b want %h/%b/%b", got,
                     sum, cout, overflow, e.sum, e.cout, e.ovf);
            failures++;
          end
        end
        got++;
      end
    end
    checks++;
    if (exp_q.size() != 0 || sent != got) begin
      $display("FAIL rand_drain: got sent=%0d received=%0d pending=%0d want equal/0", sent, got,
               exp_q.size());
      failures++;
    end
    $display("test_random sent=%0d received=%0d", sent, got);
  endtask

  task automatic test_reset_midflight();
    res_t e;
    int   seen;
    exp_q.delete();
    for (int i = 0; i < 3; i++) drive(1'b1, rand_operand(), rand_operand(), 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    checks++;
    if (out_valid !== 1'b1) begin
      $display("FAIL midrst_pre_valid: got out_valid=%b want 1", out_valid);
      failures++;
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || overflow !== 1'b0) begin
      $display("FAIL midrst_async: got v=%b sum=%h cout=%b ovf=%b want 0/0/0/0", out_valid,
               sum, cout, overflow);
      failures++;
    end
    idle(1'b0);
    idle(1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL midrst_in_ready: got %b want 1", in_ready);
      failures++;
    end
    for (int i = 0; i < 10; i++) begin
      idle(1'b1);
      checks++;
      if (out_valid !== 1'b0) begin
        $display("FAIL midrst_ghost: cycle %0d got out_valid=%b want 0", i, out_valid);
        failures++;
      end
    end
    drive(1'b1, 16'h00FF, 16'h0F01, 1'b1, 1'b1, 1'b1);
    e = model(16'h00FF, 16'h0F01, 1'b1, 1'b1);
    seen = 0;
    for (int cyc = 0; cyc < 10 && seen == 0; cyc++) begin
      idle(1'b1);
      if (out_valid === 1'b1) begin
        seen = 1;
        checks++;
        if (sum !== e.sum || cout !== e.cout || overflow !== e.ovf) begin
          $display("FAIL midrst_after: got sum=%h cout=%b want %h/%b", sum, cout, e.sum, e.cout);
          failures++;
        end
      end
    end
    checks++;
    if (seen != 1) begin
      $display("FAIL midrst_timeout: got no result want 1");
      failures++;
    end
    $display("test_reset_midflight post-reset sum=%h cout=%b", sum, cout);
  endtask

  task automatic test_single_stage();
    @(negedge clk);
    in_valid8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; sub8 = 1'b0; out_ready8 = 1'b1;
    #1;
    checks++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
      $display("FAIL single_accept: got in_ready=%b out_valid=%b want 1/0", in_ready8, out_valid8);
      failures++;
    end
    @(negedge clk);
    in_valid8 = 1'b0;
    #1;
    checks++;
    if (out_valid8 !== 1'b1 || sum8 !== 8'h00 || cout8 !== 1'b1 || overflow8 !== 1'b0) begin
      $display("FAIL single_result: got v=%b sum=%h cout=%b ovf=%b want 1/00/1/0", out_valid8,
               sum8, cout8, overflow8);
      failures++;
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid8 !== 1'b0) begin
      $display("FAIL single_dup: got out_valid=%b want 0", out_valid8);
      failures++;
    end
    $display("test_single_stage AA+55+1 -> sum=%h cout=%b", 8'h00, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b0;
    test_reset();
    test_latency();
    test_wrap();
    test_overflow();
    test_single_stage();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits; legal values 4..64.
REQ-002 Parameter STAGES, default 4, pipeline depth; legal values 1..WIDTH; WIDTH SHALL be an integer multiple of STAGES.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port in_valid  input  1  a, b, cin and sub carry a valid operation.
REQ-006 Port in_ready  output  1  the block accepts the operation this cycle.
REQ-007 Port a  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 Port b  input  WIDTH  operand B.
REQ-009 Port cin  input  1  carry-in (borrow-in when sub=1).
REQ-010 Port sub  input  1  0 = add, 1 = subtract.
REQ-011 Port out_valid  output  1  sum, cout and overflow hold a valid result.
REQ-012 Port out_ready  input  1  the downstream consumer takes the result this cycle.
REQ-013 Port sum  output  WIDTH  result bits.
REQ-014 Port cout  output  1  carry-out of the MSB.
REQ-015 Port overflow  output  1  signed overflow flag (see Configuration).

Function
REQ-016 Effective B SHALL be b XOR {WIDTH{sub}}; effective carry-in SHALL be cin XOR sub.
- Result: {cout, sum} = a + effective B + effective carry-in, computed modulo 2^(WIDTH+1).
REQ-017 Slice k (0..STAGES-1) SHALL add bits [k*WIDTH/STAGES +: WIDTH/STAGES] in pipeline stage k.
- Its carry-in is the registered carry-out of slice k-1; slice 0 uses the effective carry-in.
REQ-018 Unprocessed operand slices and completed sum slices SHALL be carried forward in skew registers, so each operation stays aligned as one token.
REQ-019 Latency SHALL be exactly STAGES cycles from the accepting edge to out_valid=1, when there is no stall.
REQ-020 Throughput SHALL be one operation per cycle while out_ready=1.
REQ-021 The pipeline SHALL advance only when advance = out_ready OR NOT out_valid.
- On a stall, every stage holds its contents; a stall does not collapse bubbles.
REQ-022 in_ready SHALL equal advance (combinational); an operation is accepted only on a cycle where in_valid AND in_ready are both 1.
REQ-023 A cycle with in_valid=0 and advance=1 SHALL inject a bubble (stage valid=0).
REQ-024 While out_valid=1 and out_ready=0, sum, cout and overflow SHALL remain stable until the transfer completes.
REQ-025 Simultaneous accept and output transfer SHALL be legal in the same cycle.
- A full pipeline with out_ready=1 accepts a new operation every cycle with no loss.
REQ-026 Wrap-around: sum SHALL wrap modulo 2^WIDTH, with the carry reported only on cout.
- In subtract mode, cout=1 means no borrow.
REQ-027 When out_valid=0, the values of sum, cout and overflow SHALL be don't-care to consumers.
- Implementation drives the last-stage register contents.

Reset
REQ-028 Asserting rst SHALL immediately clear all stage valid bits, out_valid, sum, cout, overflow and all skew/carry registers to 0.
REQ-029 Reset mid-operation SHALL discard all in-flight operations; none SHALL appear at the output after reset.
REQ-030 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-031 Macro PIPELINED_ADDER_OVF_EN SHALL control the signed overflow logic.
- Defined: overflow = carry into MSB XOR carry out of MSB, registered in the final stage and aligned with sum.
- Not defined: overflow is tied to 0, no overflow logic is present, and the port list is unchanged.

Verification (WIDTH=16, STAGES=4 unless noted)
REQ-032 a=0x1234, b=0x0F0F, cin=0, sub=0, single accept, out_ready=1 -> exactly 4 cycles later out_valid=1, sum=0x2143, cout=0.
REQ-033 a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1; then a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0.
REQ-034 Back-to-back burst of 8 operations with out_ready held 0 from cycle 5 for 3 cycles.
- Required: in_ready=0 during the stall; no result is lost or duplicated; results emerge in order with held values during the stall.
REQ-035 With PIPELINED_ADDER_OVF_EN defined: a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, overflow=1.
- Without the macro, the same stimulus gives overflow=0.
REQ-036 Assert rst two cycles after accepting three operations -> out_valid=0 immediately and stays 0 until new operations are accepted; in_ready=1 after release.
REQ-037 WIDTH=8, STAGES=1: a=0xAA, b=0x55, cin=1 -> sum=0x00, cout=1 after 1 cycle.
